// File: rtl/dmem_master.sv
// rtl/dmem_master.sv - byte-addressed load/store initiator for a word-addressed data memory
//
// Purpose: accepts byte/half/word load and store requests over a valid/ready
// handshake and turns them into single-cycle read/write strobes toward a
// 32-bit word memory. Sub-word loads are lane-extracted and sign/zero
// extended; sub-word stores are done as read-modify-write. Misaligned,
// illegal-size and out-of-range requests complete with resp_err and no strobe.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write, req_size, req_signed   store/load, 00 byte 01 half 10 word, sign-extend
//   req_addr, req_wdata               byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err  one-cycle completion, load data, error flag
//   mem_address                       word index (req_addr >> 2)
//   mem_dataIn, mem_dataOut           write word / read word
//   mem_readmode, mem_writemode       single-cycle read / write strobes
module dmem_master #(
  parameter int unsigned MEM_WORDS = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  output logic        mem_readmode,
  output logic        mem_writemode,
  input  logic [31:0] mem_dataOut
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RCAP, S_WR, S_WREL, S_RESP} state_t;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;    // only the low half is ever merged into a word
  logic [31:0] result_q;
  logic        err_q;

  logic        req_err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  assign req_ready = (state_q == S_IDLE);

  // Request legality, evaluated on the live request fields at acceptance.
  always_comb begin
    req_err_d = 1'b0;
    case (req_size)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = req_addr[0];
      2'b10:   req_err_d = |req_addr[1:0];
      default: req_err_d = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) req_err_d = 1'b1;
  end

  // Lane extraction and read-modify-write merge on the word read in RCAP.
  always_comb begin
    byte_d  = 8'h00;
    half_d  = lane_q[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];
    merge_d = mem_dataOut;
    case (lane_q)
      2'd0: begin byte_d = mem_dataOut[7:0];   merge_d[7:0]   = wdata_q[7:0]; end
      2'd1: begin byte_d = mem_dataOut[15:8];  merge_d[15:8]  = wdata_q[7:0]; end
      2'd2: begin byte_d = mem_dataOut[23:16]; merge_d[23:16] = wdata_q[7:0]; end
      default: begin byte_d = mem_dataOut[31:24]; merge_d[31:24] = wdata_q[7:0]; end
    endcase
    case (size_q)
      2'b00: load_d = {{24{signed_q & byte_d[7]}}, byte_d};
      2'b01: begin
        load_d = {{16{signed_q & half_d[15]}}, half_d};
        merge_d = mem_dataOut;
        if (lane_q[1]) merge_d[31:16] = wdata_q;
        else           merge_d[15:0]  = wdata_q;
      end
      default: load_d = mem_dataOut;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      result_q      <= 32'h0;
      err_q         <= 1'b0;
      mem_address   <= 32'h0;
      mem_dataIn    <= 32'h0;
      mem_readmode  <= 1'b0;
      mem_writemode <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_err      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            size_q      <= req_size;
            signed_q    <= req_signed;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            mem_address <= {2'b00, req_addr[31:2]};
            result_q    <= 32'h0;
            err_q       <= req_err_d;
            if (req_err_d) begin
              state_q <= S_RESP;
            end else if (req_write && req_size == 2'b10) begin
              // Word store needs no read: data is loaded a cycle ahead of the strobe.
              mem_dataIn <= req_wdata;
              state_q    <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          mem_readmode <= 1'b1;
          state_q      <= S_RCAP;
        end
        S_RCAP: begin
          mem_readmode <= 1'b0;
          if (write_q) begin
            mem_dataIn <= merge_d;
            state_q    <= S_WR;
          end else begin
            result_q <= load_d;
            state_q  <= S_RESP;
          end
        end
        S_WR: begin
          mem_writemode <= 1'b1;
          state_q       <= S_WREL;
        end
        S_WREL: begin
          mem_writemode <= 1'b0;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= result_q;
          resp_err   <= err_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// tb/tb_dmem_master.sv - self-checking bench for dmem_master
module tb_dmem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic        mem_readmode;
  logic        mem_writemode;
  logic [31:0] mem_dataOut;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [31:0] mem [0:63];
  logic        prev_rd, prev_wr;

  dmem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_readmode(mem_readmode), .mem_writemode(mem_writemode),
    .mem_dataOut(mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read word available while the strobe is high, write on the edge.
  assign mem_dataOut = mem[mem_address[5:0]];
  always @(posedge clk) if (mem_writemode) mem[mem_address[5:0]] <= mem_dataIn;

  // Strobe rules: never together, each pulse followed by a low cycle.
  initial begin prev_rd = 1'b0; prev_wr = 1'b0; end
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_readmode && mem_writemode) viol++;
      if (mem_readmode && prev_rd) viol++;
      if (mem_writemode && prev_wr) viol++;
    end
    prev_rd = mem_readmode;
    prev_wr = mem_writemode;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd_at;
    int          exp_wr_at;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rdata,
                     input int lat, input int rd_at, input int wr_at,
                     input logic [31:0] din);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = lat;
    v.exp_rd_at = rd_at; v.exp_wr_at = wr_at; v.exp_din = din;
    vecs.push_back(v);
  endtask

  // Presents a request in an IDLE cycle and follows it to its response.
  task automatic run_vec(input int idx, input vec_t v);
    int rd_at, wr_at, lat;
    logic [31:0] din;
    string tag;
    tag = $sformatf("v%0d", idx);
    req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, " mem_address"}, mem_address, v.addr >> 2);
    rd_at = 0; wr_at = 0; lat = 0; din = 32'h0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (mem_readmode && rd_at == 0) rd_at = k;
      if (mem_writemode && wr_at == 0) begin wr_at = k; din = mem_dataIn; end
      if (resp_valid) lat = k;
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
    chk({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, " read_strobe_cycle"}, rd_at, v.exp_rd_at);
    chk({tag, " write_strobe_cycle"}, wr_at, v.exp_wr_at);
    if (v.exp_wr_at != 0) chk({tag, " mem_dataIn"}, din, v.exp_din);
  endtask

  initial begin
    int pulses;
    vec_t v;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;

    //   wr  size  sgn addr        wdata        err exp_rdata    lat rd wr din
    add(1, 2'b10, 0, 32'h10,     32'hDEADBEEF, 0, 32'h0,        3, 0, 1, 32'hDEADBEEF);
    add(0, 2'b00, 1, 32'h11,     32'h0,        0, 32'hFFFFFFBE, 3, 1, 0, 32'h0);
    add(0, 2'b00, 0, 32'h11,     32'h0,        0, 32'h000000BE, 3, 1, 0, 32'h0);
    add(1, 2'b00, 0, 32'h12,     32'h00000055, 0, 32'h0,        5, 1, 3, 32'hDE55BEEF);
    add(0, 2'b10, 0, 32'h10,     32'h0,        0, 32'hDE55BEEF, 3, 1, 0, 32'h0);
    add(0, 2'b01, 0, 32'h13,     32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    add(1, 2'b10, 0, 32'h9C40,   32'h12345678, 1, 32'h0,        1, 0, 0, 32'h0);
    add(0, 2'b11, 0, 32'h10,     32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    add(0, 2'b01, 1, 32'h12,     32'h0,        0, 32'hFFFFDE55, 3, 1, 0, 32'h0);
    add(0, 2'b01, 0, 32'h10,     32'h0,        0, 32'h0000BEEF, 3, 1, 0, 32'h0);
    add(1, 2'b01, 0, 32'h10,     32'hABCD1234, 0, 32'h0,        5, 1, 3, 32'hDE551234);
    add(0, 2'b00, 1, 32'h13,     32'h0,        0, 32'hFFFFFFDE, 3, 1, 0, 32'h0);
    add(1, 2'b00, 0, 32'h13,     32'hFFFFFF80, 0, 32'h0,        5, 1, 3, 32'h80551234);
    add(0, 2'b10, 0, 32'h10,     32'h0,        0, 32'h80551234, 3, 1, 0, 32'h0);
    add(0, 2'b10, 0, 32'h9C3C,   32'h0,        0, 32'h0,        3, 1, 0, 32'h0);
    add(1, 2'b01, 0, 32'h11,     32'h0000FFFF, 1, 32'h0,        1, 0, 0, 32'h0);
    add(0, 2'b00, 1, 32'h10,     32'h0,        0, 32'h00000034, 3, 1, 0, 32'h0);
    add(1, 2'b10, 0, 32'h14,     32'h11223344, 0, 32'h0,        3, 0, 1, 32'h11223344);

    // Reset values take effect with no clock edge.
    #3;
    chk("reset mem_readmode", {31'b0, mem_readmode}, 32'd0);
    chk("reset mem_writemode", {31'b0, mem_writemode}, 32'd0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset mem_dataIn", mem_dataIn, 32'h0);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", {31'b0, req_ready}, 32'd1);

    // Table vectors run back-to-back: each is presented in the cycle after RESP.
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while a byte store is in its read strobe.
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h000000AA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst seq read strobe high", {31'b0, mem_readmode}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst seq read strobe dropped", {31'b0, mem_readmode}, 32'd0);
    chk("rst seq write strobe low", {31'b0, mem_writemode}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst seq ready after release", {31'b0, req_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (resp_valid || mem_writemode) pulses++;
    end
    chk("rst seq no response or write", pulses, 32'd0);
    chk("rst seq memory word 5 untouched", mem[5], 32'h11223344);
    v.wr = 1'b0; v.size = 2'b10; v.sgn = 1'b0; v.addr = 32'h14; v.wdata = 32'h0;
    v.exp_err = 1'b0; v.exp_rdata = 32'h11223344; v.exp_lat = 3;
    v.exp_rd_at = 1; v.exp_wr_at = 0; v.exp_din = 32'h0;
    run_vec(100, v);

    repeat (2) @(posedge clk);
    chk("strobe rule violations", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
Name: dmem_master

Overview:
Initiator side of the data-memory strobe interface. Sits between the MEM pipeline stage and the word-addressed data memory. Accepts byte-addressed load/store requests over a valid/ready handshake and converts them into single-cycle read/write strobes. Provides byte, halfword and word access, with load sign/zero extension and read-modify-write for sub-word stores. Reports misaligned and out-of-range accesses as errors.

Parameters:
MEM_WORDS, 10000, depth of the attached data memory in 32-bit words; word index >= MEM_WORDS is out of range.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high in IDLE; a request is accepted when req_valid && req_ready at a clk edge
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned for sub-word stores
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
resp_err  out  1  valid with resp_valid; 1 = misaligned, illegal size or out of range
mem_address  out  32  word index = req_addr >> 2
mem_dataIn  out  32  write word to memory
mem_readmode  out  1  read strobe
mem_writemode  out  1  write strobe
mem_dataOut  in  32  read word from memory, valid the cycle after the read strobe rises

Behaviour:
- Reset (async, rst_n low): state=IDLE; mem_readmode=0, mem_writemode=0, mem_address=0, mem_dataIn=0, resp_valid=0, resp_rdata=0, resp_err=0. Takes effect immediately with no clock required. req_ready=1 once rst_n is released.
- All outputs except req_ready are registered. req_ready = (state==IDLE).
- States: IDLE, RD, RCAP, WR, WREL, RESP.
- IDLE, request accepted: latch all request fields. Drive mem_address = req_addr[31:2].
  - Error if: size==11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2] >= MEM_WORDS. On error go to RESP with resp_err=1 and no strobe.
  - Word store: load mem_dataIn=req_wdata, then go to WR.
  - All other requests: go to RD.
- RD: mem_readmode=1 for exactly this cycle. Next state RCAP.
- RCAP: mem_readmode=0. Capture mem_dataOut.
  - Load: extract the lane and extend into resp_rdata, then go to RESP.
  - Sub-word store: merge the new lane into the captured word, load mem_dataIn, then go to WR.
- Lane mapping is little-endian:
  - Byte lane k = bits 8k+7:8k, with k = addr[1:0].
  - Half at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
  - Bytes outside the lane are left unchanged by stores.
- WR: mem_writemode=1 for exactly this cycle. Next state WREL.
- WREL: mem_writemode=0. Next state RESP.
- RESP: resp_valid=1 for one cycle, then return to IDLE. resp_rdata and resp_err hold until the next RESP.
- Strobe rules:
  - mem_readmode and mem_writemode are never high together.
  - Each strobe is a single-cycle pulse followed by at least one low cycle.
  - mem_address is stable from acceptance until the return to IDLE.
  - mem_dataIn is stable the cycle before the rise of mem_writemode and through its fall.
- Latency from the acceptance edge T to resp_valid high:
  - Error: T+1.
  - Word load, word store: T+3.
  - Sub-word load: T+3.
  - Sub-word store: T+5.
- No new request is accepted before the RESP cycle completes, so there is no overlap.
- Back-to-back: a request presented in the cycle after RESP is accepted on that cycle's edge.
- Reset mid-transaction: strobes drop immediately, the transaction is abandoned and no resp_valid is issued.
  - Reset during RD/RCAP of a sub-word store: memory is not written.
  - Reset during WR: the write may already have occurred; this is acceptable.
- req_valid in non-IDLE states is ignored. The requester must hold its request until it is accepted.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF -> mem_address=4, mem_writemode pulses at T+1 with mem_dataIn=0xDEADBEEF, resp_valid at T+3 with err=0.
- Signed byte load addr 0x11 (memory word 4 = 0xDEADBEEF) -> mem_readmode pulse at T+1, resp_rdata=0xFFFFFFBE at T+3. The same load unsigned -> 0x000000BE.
- Byte store 0x55 at addr 0x12 -> read pulse at T+1, write pulse at T+3 with mem_dataIn=0xDE55BEEF, resp at T+5. A following word load of 0x10 returns 0xDE55BEEF.
- Errors:
  - Half load at 0x13 -> resp_err=1 at T+1, no strobes.
  - Word store at byte address 40000 (word 10000) -> resp_err=1 at T+1, no strobes.
  - size=11 -> resp_err=1 at T+1, no strobes.
- Signed half load at 0x12 (word 0xDE55BEEF) -> resp_rdata=0xFFFFDE55. Back-to-back requests accepted in the cycle after each RESP; check strobes never overlap and each is followed by a low cycle.
- Assert rst_n=0 while in RD of a sub-word store -> mem_readmode=0 immediately, no resp_valid, memory unchanged. After release, req_ready=1 and a word load completes normally at T+3.
